// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, oversampling factor and default frame
// parameters shared by the UART transmitter and receiver.
package uart_pkg;
    localparam int OS_TICKS    = 16;
    localparam int DEF_D_BIT   = 8;
    localparam int DEF_SB_TICK = 16;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, LSB first, 16x oversampled by an external s_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int D_BIT   = DEF_D_BIT,
    parameter int SB_TICK = DEF_SB_TICK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_tick,
    input  logic             tx_start,
    input  logic [D_BIT-1:0] din,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done_tick
);
    localparam logic [4:0] LAST_OS  = 5'(OS_TICKS - 1);
    localparam logic [4:0] LAST_SB  = 5'(SB_TICK - 1);
    localparam logic [2:0] LAST_BIT = 3'(D_BIT - 1);

    state_t           r_state, w_state_n;
    logic [4:0]       r_s, w_s_n;
    logic [2:0]       r_n, w_n_n;
    logic [D_BIT-1:0] r_b, w_b_n;
    logic             r_tx, w_tx_n;
    logic             w_done;
`ifdef UART_TX_PARITY_EN
    logic             r_par, w_par_n;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_s     <= w_s_n;
            r_n     <= w_n_n;
            r_b     <= w_b_n;
            r_tx    <= w_tx_n;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_n;
`endif
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_s_n     = r_s;
        w_n_n     = r_n;
        w_b_n     = r_b;
        w_done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_n   = r_par;
`endif
        case (r_state)
            IDLE: if (tx_start) begin
                w_state_n = START;
                w_s_n     = '0;
                w_b_n     = din;
`ifdef UART_TX_PARITY_EN
                w_par_n   = ^din;
`endif
            end
            START: if (s_tick) begin
                if (r_s == LAST_OS) begin
                    w_state_n = DATA;
                    w_s_n     = '0;
                    w_n_n     = '0;
                end else w_s_n = r_s + 5'd1;
            end
            DATA: if (s_tick) begin
                if (r_s == LAST_OS) begin
                    w_s_n = '0;
                    w_b_n = r_b >> 1;
`ifdef UART_TX_PARITY_EN
                    if (r_n == LAST_BIT) w_state_n = PARITY;
`else
                    if (r_n == LAST_BIT) w_state_n = STOP;
`endif
                    else w_n_n = r_n + 3'd1;
                end else w_s_n = r_s + 5'd1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (s_tick) begin
                if (r_s == LAST_OS) begin
                    w_state_n = STOP;
                    w_s_n     = '0;
                end else w_s_n = r_s + 5'd1;
            end
`endif
            STOP: if (s_tick) begin
                if (r_s == LAST_SB) begin
                    w_state_n = IDLE;
                    w_done    = 1'b1;
                end else w_s_n = r_s + 5'd1;
            end
            default: begin
                w_state_n = IDLE;
                w_s_n     = '0;
                w_n_n     = '0;
            end
        endcase
        // tx is derived from the next state so it flips on the same edge as the state
`ifdef UART_TX_PARITY_EN
        w_tx_n = (w_state_n == START)  ? 1'b0 :
                 (w_state_n == DATA)   ? w_b_n[0] :
                 (w_state_n == PARITY) ? w_par_n : 1'b1;
`else
        w_tx_n = (w_state_n == START) ? 1'b0 :
                 (w_state_n == DATA)  ? w_b_n[0] : 1'b1;
`endif
    end

    assign tx           = r_tx;
    assign tx_busy      = (r_state != IDLE);
    assign tx_done_tick = w_done;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a tick-count frame model checked every cycle.
// Honours UART_TX_PARITY_EN (parity frame of 8'h07 with a 32-tick stop bit).
module tb_uart_tx;
    localparam int D = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1, SBT = 32;
    localparam logic [7:0]  LIT_D   = 8'h07;
    localparam logic [11:0] LIT_SEQ = 12'b0110_0000_1110;
    localparam int LIT_NB = 11, LIT_CHG = 3, LIT_GAP = 192, LIT_TAIL = 192;
`else
    localparam int P = 0, SBT = 16;
    localparam logic [7:0]  LIT_D   = 8'hA5;
    localparam logic [11:0] LIT_SEQ = 12'b0011_0100_1010;
    localparam int LIT_NB = 10, LIT_CHG = 7, LIT_GAP = 64, LIT_TAIL = 128;
`endif
    localparam int NDB = 16 * (1 + D + P);
    localparam int TOT = NDB + SBT;

    logic clk = 1'b0, reset, s_tick, tx_start;
    logic [D-1:0] din;
    logic tx, tx_busy, tx_done_tick;
    int total = 0, bad = 0, tick_cyc = 0;

    uart_tx #(.D_BIT(D), .SB_TICK(SBT)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
        .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
    );

    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_cyc++;
            s_tick = (tick_cyc % 4 == 0);
        end
    end

    // Frame model: position within a frame is just the number of s_ticks seen since acceptance.
    bit   m_active = 1'b0, m_valid = 1'b0;
    int   m_k = 0;
    logic m_bits [0:15];

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_valid  = 1'b1;
        end else if (!m_active) begin
            if (tx_start) begin
                m_bits[0] = 1'b0;
                for (int i = 0; i < D; i++) m_bits[i+1] = din[i];
                m_bits[D+1] = ^din;
                m_active = 1'b1;
                m_k      = 0;
            end
        end else if (s_tick) begin
            m_k++;
            if (m_k == TOT) m_active = 1'b0;
        end
    end

    function automatic logic exp_tx();
        return !m_active ? 1'b1 : (m_k < NDB ? m_bits[m_k/16] : 1'b1);
    endfunction

    task automatic chk1(string nm, logic a, logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
        end
    endtask

    task automatic chkn(string nm, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    always @(negedge clk) if (m_valid) begin
        chk1("cyc_tx", tx, exp_tx());
        chk1("cyc_busy", tx_busy, m_active);
        chk1("cyc_done", tx_done_tick, m_active && s_tick && m_k == TOT - 1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start(logic [D-1:0] d);
        tx_start = 1'b1;
        din      = d;
        step();
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(string nm);
        int n = 0;
        while (tx_busy !== 1'b0 && n < 3000) begin
            step();
            n++;
        end
        chk1({nm, "_idle_timeout"}, tx_busy, 1'b0);
    endtask

    task automatic frame_literal();
        logic [11:0] seq = LIT_SEQ;
        int   c = 0, dn = 0, fall = -1, last;
        int   q[$];
        logic pv;
        start(LIT_D);
        din = ~LIT_D;
        pv  = tx;
        while (fall < 0 && c < 2000) begin
            step();
            c++;
            if (tx_done_tick === 1'b1) dn++;
            if (tx !== pv) begin
                q.push_back(c);
                pv = tx;
            end
            if (c % 64 == 32 && c / 64 < LIT_NB) chk1($sformatf("lit_bit%0d", c / 64), tx, seq[c/64]);
            if (tx_busy === 1'b0) fall = c;
        end
        last = (q.size() > 0) ? q[q.size()-1] : -9999;
        chkn("lit_ended", int'(fall >= 0), 1);
        chkn("lit_done_count", dn, 1);
        chkn("lit_changes", q.size(), LIT_CHG);
        chkn("lit_gap", (q.size() >= 2) ? q[1] - q[0] : -1, LIT_GAP);
        chkn("lit_tail", fall - last, LIT_TAIL);
    endtask

    task automatic send_decode(logic [7:0] d, bit inj);
        logic [7:0] r = '0;
        start(d);
        repeat (31) step();
        chk1("rx_start_bit", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 64; j++) begin
                tx_start = inj && i == 3 && j == 10;
                if (tx_start) din = 8'h11;
                step();
            end
            tx_start = 1'b0;
            if (inj && i == 3) chk1("mid_start_busy", tx_busy, 1'b1);
            r[i] = tx;
        end
        if (P == 1) begin
            repeat (64) step();
            chk1("rx_parity", tx, ^d);
        end
        repeat (64) step();
        chk1("rx_stop_bit", tx, 1'b1);
        chkn($sformatf("rx_byte_%02h", d), int'(r), int'(d));
        wait_idle("rx");
    endtask

    task automatic back_to_back();
        int n = 0;
        start(8'h96);
        while (!(m_active && s_tick && m_k == TOT - 1) && n < 3000) begin
            step();
            n++;
        end
        chk1("b2b_done_cycle", tx_done_tick, 1'b1);
        tx_start = 1'b1;
        din      = 8'h5A;
        step();
        chk1("b2b_ignored_busy", tx_busy, 1'b0);
        chk1("b2b_ignored_tx", tx, 1'b1);
        step();
        tx_start = 1'b0;
        chk1("b2b_accept_tx", tx, 1'b0);
        chk1("b2b_accept_busy", tx_busy, 1'b1);
        wait_idle("b2b");
    endtask

    task automatic reset_mid();
        int n = 0;
        start(8'hA5);
        while (!(m_active && m_k == 56) && n < 1000) begin
            step();
            n++;
        end
        chkn("rm_reached_bit2", m_k, 56);
        reset = 1'b1;
        step();
        chk1("rm_tx", tx, 1'b1);
        chk1("rm_busy", tx_busy, 1'b0);
        chk1("rm_done", tx_done_tick, 1'b0);
        reset = 1'b0;
        repeat (80) step();
    endtask

    initial begin
        reset    = 1'b1;
        tx_start = 1'b0;
        din      = '0;
        repeat (3) step();
        chk1("rst_tx", tx, 1'b1);
        chk1("rst_busy", tx_busy, 1'b0);
        chk1("rst_done", tx_done_tick, 1'b0);
        reset = 1'b0;
        step();
        frame_literal();
        send_decode(8'h00, 1'b0);
        send_decode(8'hFF, 1'b0);
        send_decode(8'h3C, 1'b1);
        back_to_back();
        reset_mid();
        repeat (20) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter D_BIT, default 8: number of data bits per frame; legal range 5..8.
REQ-002 Parameter SB_TICK, default 16: stop-bit duration in s_tick pulses (16 = 1, 24 = 1.5, 32 = 2 stop bits); legal values 16, 24, 32.
REQ-003 clk  input  1  single system clock; all logic rising-edge triggered.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_tick  input  1  one-cycle enable pulse at 16x baud rate, from external baud generator.
REQ-006 tx_start  input  1  request to transmit din; sampled only in IDLE.
REQ-007 din  input  D_BIT  data word to send; captured on the accepted tx_start cycle.
REQ-008 tx  output  1  serial line, registered, idles high.
REQ-009 tx_busy  output  1  high whenever state is not IDLE.
REQ-010 tx_done_tick  output  1  one-clock pulse at end of stop bit.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY (macro-dependent), STOP.
REQ-012 In IDLE, tx SHALL be 1; tx_start=1 SHALL latch din into shift register, clear tick counter, and enter START next clock.
REQ-013 tx SHALL change to the new bit value on the same clock edge as the state change, with no combinational path from inputs to tx.
REQ-014 START SHALL drive tx=0 for 16 s_tick pulses, then clear the counter, clear the bit counter, and enter DATA.
REQ-015 DATA SHALL drive shift-register bit 0 (LSB first) for 16 s_tick pulses per bit, then shift right by one; after bit D_BIT-1 go to PARITY if enabled, else STOP.
REQ-016 STOP SHALL drive tx=1 for SB_TICK s_tick pulses; on the last pulse, assert tx_done_tick for exactly one clock and enter IDLE.
REQ-017 Clocks without s_tick SHALL hold all state, counters and tx unchanged.
REQ-018 tx_start while tx_busy=1 (including the tx_done_tick cycle) SHALL be ignored; a start in the first IDLE cycle after done SHALL be accepted (minimum one-clock inter-frame gap).
REQ-019 din changes after acceptance SHALL NOT affect the frame in flight.
REQ-020 Tick counter SHALL be 5 bits wide; bit counter SHALL be 3 bits wide; no wrap-around within a legal frame.
REQ-021 Illegal state encodings SHALL return to IDLE on the next clock with tx=1.

Reset
REQ-022 On reset: state=IDLE, counters=0, shift register=0, tx=1, tx_busy=0, tx_done_tick=0, all effective next clock edge.
REQ-023 Reset mid-frame SHALL abort the frame with no tx_done_tick, and tx SHALL be 1 after the reset edge.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined: after DATA, the PARITY state SHALL drive even parity (XOR of the D_BIT latched bits) for 16 s_tick pulses, then enter STOP.
REQ-025 UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent; DATA goes directly to STOP.

Structure
REQ-026 A shared package uart_pkg SHALL hold the state encoding constants, the oversampling factor 16, and default D_BIT/SB_TICK values, also for use by the receiver.
REQ-027 No sub-module: the baud tick generator stays external and is shared with the receiver.

Verification
REQ-028 s_tick every 4 clocks, din=8'hA5, no parity: tx shows 0,1,0,1,0,0,1,0,1,1, each bit exactly 64 clocks; stop bit 16 ticks; one tx_done_tick.
REQ-029 Loopback into the receiver (D_BIT=8, SB_TICK=16), bytes 8'h00, 8'hFF, 8'h3C: receiver dout matches each byte.
REQ-030 Assert tx_start mid-DATA with din=8'h11: ignored; frame in flight unchanged; tx_busy stays 1.
REQ-031 Assert tx_start during the tx_done_tick cycle, then again next cycle: first ignored, second starts a frame with tx=0 one clock later.
REQ-032 Reset asserted on the 3rd data bit: tx=1, tx_busy=0 after the edge; no tx_done_tick.
REQ-033 UART_TX_PARITY_EN defined, din=8'h07: parity bit 1 between bit 7 and stop; SB_TICK=32 gives a 32-tick stop bit.
